// File: rtl/i_cache_axi_nway_if.sv
// rtl/i_cache_axi_nway_if.sv - fetch, invalidate and AXI read-channel bundle for i_cache_axi_nway
// slave is the cache side; master is the fetch stage plus AXI memory side.
interface i_cache_axi_nway_if #(
  parameter int INDEX_WIDTH = 7,
  parameter int FETCH_NUM   = 2
);
  logic                     req_valid;
  logic                     req_ready;
  logic [31:0]              req_addr;
  logic                     req_uncached;
  logic                     resp_valid;
  logic                     resp_ready;
  logic [32*FETCH_NUM-1:0]  resp_data;
  logic [FETCH_NUM-1:0]     resp_mask;
  logic                     inv_valid;
  logic                     inv_ready;
  logic [INDEX_WIDTH-1:0]   inv_index;
  logic [31:0]              araddr;
  logic [7:0]               arlen;
  logic                     arvalid;
  logic                     arready;
  logic [31:0]              rdata;
  logic                     rvalid;
  logic                     rlast;
  logic                     rready;

  modport slave (
    input  req_valid, req_addr, req_uncached, resp_ready, inv_valid, inv_index,
           arready, rdata, rvalid, rlast,
    output req_ready, resp_valid, resp_data, resp_mask, inv_ready,
           araddr, arlen, arvalid, rready
  );

  modport master (
    output req_valid, req_addr, req_uncached, resp_ready, inv_valid, inv_index,
           arready, rdata, rvalid, rlast,
    input  req_ready, resp_valid, resp_data, resp_mask, inv_ready,
           araddr, arlen, arvalid, rready
  );
endinterface

// File: rtl/i_cache_axi_nway.sv
// rtl/i_cache_axi_nway.sv - set-associative instruction cache with round-robin refill over an AXI read burst
// Returns up to FETCH_NUM words of one line per request; uncached requests go out as single beats.
module i_cache_axi_nway #(
  parameter int WAY_NUM      = 4,
  parameter int INDEX_WIDTH  = 7,
  parameter int OFFSET_WIDTH = 5,
  parameter int FETCH_NUM    = 2,
  parameter int TAG_WIDTH    = 32 - INDEX_WIDTH - OFFSET_WIDTH
) (
  input logic              clk,
  input logic              rst,
  i_cache_axi_nway_if.slave bus
);
  localparam int SETS   = 1 << INDEX_WIDTH;
  localparam int WORDS  = 1 << (OFFSET_WIDTH - 2);
  localparam int WORD_W = OFFSET_WIDTH - 2;
  localparam int WAY_W  = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1;

  typedef enum logic [2:0] {IDLE, LOOKUP, MISS_AR, MISS_R, UNC_AR, UNC_R, RESP} state_t;
  state_t state, state_nxt;

  logic [TAG_WIDTH-1:0] tag_mem  [WAY_NUM][SETS];
  logic [31:0]          data_mem [WAY_NUM][SETS][WORDS];
  logic [WAY_NUM-1:0]   valid    [SETS];
  logic [WAY_W-1:0]     rr_ptr   [SETS];

  logic [TAG_WIDTH-1:0] tag_rd  [WAY_NUM];
  logic [31:0]          line_rd [WAY_NUM][WORDS];

  logic [31:0]             addr_q;
  logic [WAY_W-1:0]        victim;
  logic [WORD_W-1:0]       cnt;
  logic [32*FETCH_NUM-1:0] resp_q;
  logic [FETCH_NUM-1:0]    mask_q;

  logic [TAG_WIDTH-1:0]   tag_q;
  logic [INDEX_WIDTH-1:0] idx_q;
  logic [INDEX_WIDTH-1:0] req_idx;
  logic [WORD_W-1:0]      off_q;
  logic [WORD_W-1:0]      rel;
  logic                   req_fire;
  logic                   hit;
  logic [WAY_W-1:0]       hit_way;
  logic [FETCH_NUM-1:0]   line_mask;

  assign tag_q    = addr_q[31 -: TAG_WIDTH];
  assign idx_q    = addr_q[OFFSET_WIDTH +: INDEX_WIDTH];
  assign off_q    = addr_q[2 +: WORD_W];
  assign req_idx  = bus.req_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign rel      = cnt - off_q;
  assign req_fire = (state == IDLE) && !bus.inv_valid && bus.req_valid;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAY_NUM; w++) begin
      if (valid[idx_q][w] && (tag_rd[w] == tag_q)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Words past the end of the line are masked off and returned as zero.
  always_comb begin
    line_mask = '0;
    for (int k = 0; k < FETCH_NUM; k++)
      line_mask[k] = (int'(off_q) + k) < WORDS;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    bus.req_ready  = (state == IDLE) && !rst;
    bus.inv_ready  = (state == IDLE) && !rst;
    bus.resp_valid = (state == RESP);
    bus.arvalid    = (state == MISS_AR) || (state == UNC_AR);
    bus.rready     = (state == MISS_R) || (state == UNC_R);
    bus.araddr     = (state == UNC_AR) ? addr_q : {tag_q, idx_q, {OFFSET_WIDTH{1'b0}}};
    bus.arlen      = (state == UNC_AR) ? 8'd0 : 8'(WORDS - 1);
    bus.resp_data  = resp_q;
    bus.resp_mask  = mask_q;
    case (state)
      IDLE:    if (req_fire) state_nxt = bus.req_uncached ? UNC_AR : LOOKUP;
      LOOKUP:  state_nxt = hit ? RESP : MISS_AR;
      MISS_AR: if (bus.arready) state_nxt = MISS_R;
      MISS_R:  if (bus.rvalid && bus.rlast) state_nxt = RESP;
      UNC_AR:  if (bus.arready) state_nxt = UNC_R;
      UNC_R:   if (bus.rvalid) state_nxt = RESP;
      RESP:    if (bus.resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      victim <= '0;
      cnt    <= '0;
      resp_q <= '0;
      mask_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid[s]  <= '0;
        rr_ptr[s] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (bus.inv_valid) begin
            valid[bus.inv_index] <= '0;
          end else if (bus.req_valid) begin
            addr_q <= bus.req_addr;
            resp_q <= '0;
            mask_q <= '0;
            cnt    <= '0;
          end
        end
        LOOKUP: begin
          mask_q <= line_mask;
          victim <= rr_ptr[idx_q];
          if (hit) begin
            for (int k = 0; k < FETCH_NUM; k++)
              if (line_mask[k]) resp_q[32*k +: 32] <= line_rd[hit_way][off_q + WORD_W'(k)];
          end
        end
        MISS_R: begin
          if (bus.rvalid) begin
            cnt <= cnt + 1'b1;
            for (int k = 0; k < FETCH_NUM; k++)
              if ((cnt >= off_q) && (rel == WORD_W'(k))) resp_q[32*k +: 32] <= bus.rdata;
            if (bus.rlast) begin
              valid[idx_q][victim] <= 1'b1;
              rr_ptr[idx_q] <= (int'(rr_ptr[idx_q]) == WAY_NUM - 1) ? '0 : rr_ptr[idx_q] + 1'b1;
            end
          end
        end
        UNC_R: begin
          if (bus.rvalid) begin
            resp_q[31:0] <= bus.rdata;
            mask_q       <= FETCH_NUM'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Tag/data arrays carry no reset; validity lives entirely in valid[].
  always_ff @(posedge clk) begin
    if (req_fire && !bus.req_uncached) begin
      for (int w = 0; w < WAY_NUM; w++) begin
        tag_rd[w] <= tag_mem[w][req_idx];
        for (int i = 0; i < WORDS; i++)
          line_rd[w][i] <= data_mem[w][req_idx][i];
      end
    end
    if ((state == MISS_R) && bus.rvalid) begin
      data_mem[victim][idx_q][cnt] <= bus.rdata;
      if (bus.rlast) tag_mem[victim][idx_q] <= tag_q;
    end
  end
endmodule

// File: tb/tb_i_cache_axi_nway.sv
// tb/tb_i_cache_axi_nway.sv - directed self-checking bench for i_cache_axi_nway
// Memory model: word at byte address a reads as a ^ 32'hDEAD_BEEF.
module tb_i_cache_axi_nway;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int failures = 0;

  int          ar_count = 0;
  logic [31:0] last_araddr = '0;
  logic [7:0]  last_arlen = '0;
  int          beat = 0;

  i_cache_axi_nway_if #(.INDEX_WIDTH(7), .FETCH_NUM(2)) bus ();

  i_cache_axi_nway #(
    .WAY_NUM(4), .INDEX_WIDTH(7), .OFFSET_WIDTH(5), .FETCH_NUM(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  // AXI memory responder: arready one cycle after arvalid, then back-to-back beats.
  initial begin
    int st;
    int len;
    logic [31:0] base;
    st = 0; len = 0; base = '0;
    bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rlast = 1'b0; bus.rdata = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        st = 0; beat = 0;
        bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rlast = 1'b0;
      end else if (st == 0) begin
        if (bus.arready) begin
          bus.arready = 1'b0; st = 1; beat = 0;
          bus.rvalid = 1'b1; bus.rdata = mem_word(base); bus.rlast = (len == 0);
        end else if (bus.arvalid) begin
          bus.arready = 1'b1; base = bus.araddr; len = int'(bus.arlen);
          last_araddr = bus.araddr; last_arlen = bus.arlen; ar_count++;
        end
      end else begin
        if (bus.rlast) begin
          bus.rvalid = 1'b0; bus.rlast = 1'b0; st = 0;
        end else begin
          beat++;
          bus.rdata = mem_word(base + 32'(4 * beat)); bus.rlast = (beat == len);
        end
      end
    end
  end

  task automatic start_req(input logic [31:0] a, input logic u);
    bus.req_addr = a; bus.req_uncached = u; bus.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_resp(output logic [63:0] d, output logic [1:0] m, output int c);
    c = 1;
    while (bus.resp_valid !== 1'b1 && c < 200) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (bus.resp_valid !== 1'b1) begin
      failures++;
      $display("FAIL resp_timeout: resp_valid=%b required 1 within 200 cycles", bus.resp_valid);
    end
    d = bus.resp_data; m = bus.resp_mask;
  endtask

  task automatic consume;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
  endtask

  task automatic do_req(input logic [31:0] a, input logic u,
                        output logic [63:0] d, output logic [1:0] m, output int c);
    start_req(a, u);
    wait_resp(d, m, c);
    consume();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.arvalid !== 1'b0) begin failures++; $display("FAIL reset_arvalid: got %b required 0", bus.arvalid); end
    checks++; if (bus.rready !== 1'b0) begin failures++; $display("FAIL reset_rready: got %b required 0", bus.rready); end
    checks++; if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid: got %b required 0", bus.resp_valid); end
    checks++; if (bus.req_ready !== 1'b0) begin failures++; $display("FAIL reset_req_ready: got %b required 0", bus.req_ready); end
    checks++; if (bus.inv_ready !== 1'b0) begin failures++; $display("FAIL reset_inv_ready: got %b required 0", bus.inv_ready); end
    checks++; if (bus.resp_data !== 64'h0 || bus.resp_mask !== 2'b00) begin failures++; $display("FAIL reset_resp: data %h mask %b required 0 and 00", bus.resp_data, bus.resp_mask); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL idle_req_ready: got %b required 1", bus.req_ready); end
  endtask

  task automatic test_cold_miss_hit;
    logic [63:0] d; logic [1:0] m; int c; int n0;
    n0 = ar_count;
    do_req(32'h0000_1008, 1'b0, d, m, c);
    checks++; if (ar_count !== n0 + 1) begin failures++; $display("FAIL cold_ar_count: got %0d required %0d", ar_count, n0 + 1); end
    checks++; if (last_araddr !== 32'h0000_1000) begin failures++; $display("FAIL cold_araddr: got %h required 00001000", last_araddr); end
    checks++; if (last_arlen !== 8'd7) begin failures++; $display("FAIL cold_arlen: got %0d required 7", last_arlen); end
    checks++; if (d !== {mem_word(32'h100C), mem_word(32'h1008)}) begin failures++; $display("FAIL cold_data: got %h required %h", d, {mem_word(32'h100C), mem_word(32'h1008)}); end
    checks++; if (m !== 2'b11) begin failures++; $display("FAIL cold_mask: got %b required 11", m); end
    n0 = ar_count;
    do_req(32'h0000_1008, 1'b0, d, m, c);
    checks++; if (c !== 2) begin failures++; $display("FAIL hit_latency: got %0d required 2", c); end
    checks++; if (ar_count !== n0) begin failures++; $display("FAIL hit_no_ar: got %0d bursts required 0", ar_count - n0); end
    checks++; if (d !== {mem_word(32'h100C), mem_word(32'h1008)} || m !== 2'b11) begin failures++; $display("FAIL hit_data: got %h/%b required %h/11", d, m, {mem_word(32'h100C), mem_word(32'h1008)}); end
  endtask

  task automatic test_line_end;
    logic [63:0] d; logic [1:0] m; int c; int n0;
    n0 = ar_count;
    do_req(32'h0000_101C, 1'b0, d, m, c);
    checks++; if (ar_count !== n0) begin failures++; $display("FAIL lineend_hit: got %0d bursts required 0", ar_count - n0); end
    checks++; if (m !== 2'b01) begin failures++; $display("FAIL lineend_mask: got %b required 01", m); end
    checks++; if (d !== {32'h0, mem_word(32'h101C)}) begin failures++; $display("FAIL lineend_data: got %h required %h", d, {32'h0, mem_word(32'h101C)}); end
  endtask

  task automatic test_replacement;
    logic [63:0] d; logic [1:0] m; int c; int n0;
    logic [31:0] a;
    for (int t = 1; t <= 5; t++) begin
      a = (32'(t) << 12) | 32'h0A0;
      n0 = ar_count;
      do_req(a, 1'b0, d, m, c);
      checks++; if (ar_count !== n0 + 1) begin failures++; $display("FAIL repl_fill_%0d: got %0d bursts required 1", t, ar_count - n0); end
    end
    n0 = ar_count;
    do_req(32'h0000_10A0, 1'b0, d, m, c);
    checks++; if (ar_count !== n0 + 1) begin failures++; $display("FAIL repl_sixth_miss: got %0d bursts required 1", ar_count - n0); end
    n0 = ar_count;
    do_req(32'h0000_30A0, 1'b0, d, m, c);
    checks++; if (ar_count !== n0) begin failures++; $display("FAIL repl_tag3_hit: got %0d bursts required 0", ar_count - n0); end
    n0 = ar_count;
    do_req(32'h0000_20A0, 1'b0, d, m, c);
    checks++; if (ar_count !== n0 + 1) begin failures++; $display("FAIL repl_tag2_evicted: got %0d bursts required 1", ar_count - n0); end
    checks++; if (d !== {mem_word(32'h20A4), mem_word(32'h20A0)}) begin failures++; $display("FAIL repl_data: got %h required %h", d, {mem_word(32'h20A4), mem_word(32'h20A0)}); end
  endtask

  task automatic test_uncached;
    logic [63:0] d; logic [1:0] m; int c; int n0;
    n0 = ar_count;
    do_req(32'h1FC0_0004, 1'b1, d, m, c);
    checks++; if (ar_count !== n0 + 1 || last_araddr !== 32'h1FC0_0004 || last_arlen !== 8'd0) begin failures++; $display("FAIL unc_ar: got n=%0d addr=%h len=%0d required 1/1fc00004/0", ar_count - n0, last_araddr, last_arlen); end
    checks++; if (d !== {32'h0, mem_word(32'h1FC0_0004)} || m !== 2'b01) begin failures++; $display("FAIL unc_resp: got %h/%b required %h/01", d, m, {32'h0, mem_word(32'h1FC0_0004)}); end
    n0 = ar_count;
    do_req(32'h1FC0_0004, 1'b0, d, m, c);
    checks++; if (ar_count !== n0 + 1 || last_araddr !== 32'h1FC0_0000 || last_arlen !== 8'd7) begin failures++; $display("FAIL unc_then_cached_miss: got n=%0d addr=%h len=%0d required 1/1fc00000/7", ar_count - n0, last_araddr, last_arlen); end
    checks++; if (d !== {mem_word(32'h1FC0_0008), mem_word(32'h1FC0_0004)} || m !== 2'b11) begin failures++; $display("FAIL unc_cached_data: got %h/%b required %h/11", d, m, {mem_word(32'h1FC0_0008), mem_word(32'h1FC0_0004)}); end
  endtask

  task automatic test_invalidate;
    logic [63:0] d; logic [1:0] m; int c; int n0;
    do_req(32'h0000_2020, 1'b0, d, m, c);
    n0 = ar_count;
    do_req(32'h0000_2020, 1'b0, d, m, c);
    checks++; if (ar_count !== n0) begin failures++; $display("FAIL inv_pre_hit: got %0d bursts required 0", ar_count - n0); end
    bus.inv_index = 7'h01; bus.inv_valid = 1'b1;
    #1;
    checks++; if (bus.inv_ready !== 1'b1) begin failures++; $display("FAIL inv_ready_idle: got %b required 1", bus.inv_ready); end
    @(negedge clk);
    bus.inv_valid = 1'b0;
    n0 = ar_count;
    do_req(32'h0000_2020, 1'b0, d, m, c);
    checks++; if (ar_count !== n0 + 1) begin failures++; $display("FAIL inv_then_miss: got %0d bursts required 1", ar_count - n0); end
    bus.inv_valid = 1'b1; bus.req_addr = 32'h0000_2020; bus.req_uncached = 1'b0; bus.req_valid = 1'b1;
    @(negedge clk);
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL inv_priority_req_held: req_ready=%b required 1", bus.req_ready); end
    bus.inv_valid = 1'b0;
    n0 = ar_count;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    checks++; if (bus.req_ready !== 1'b0) begin failures++; $display("FAIL inv_priority_req_taken: req_ready=%b required 0", bus.req_ready); end
    wait_resp(d, m, c);
    consume();
    checks++; if (ar_count !== n0 + 1) begin failures++; $display("FAIL inv_priority_miss: got %0d bursts required 1", ar_count - n0); end
  endtask

  task automatic test_backpressure;
    logic [63:0] d; logic [1:0] m; int c;
    start_req(32'h0000_1008, 1'b0);
    wait_resp(d, m, c);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.resp_valid !== 1'b1 || bus.req_ready !== 1'b0 || bus.resp_data !== {mem_word(32'h100C), mem_word(32'h1008)}) begin
        failures++;
        $display("FAIL bp_hold_%0d: valid=%b req_ready=%b data=%h required 1/0/%h", i, bus.resp_valid, bus.req_ready, bus.resp_data, {mem_word(32'h100C), mem_word(32'h1008)});
      end
    end
    consume();
  endtask

  task automatic test_reset_mid_burst;
    logic [63:0] d; logic [1:0] m; int c; int n0; int guard;
    start_req(32'h0000_3000, 1'b0);
    guard = 0;
    while (!(beat == 3 && bus.rvalid === 1'b1) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checks++; if (bus.rready !== 1'b1) begin failures++; $display("FAIL midburst_reached: rready=%b required 1 at beat 3", bus.rready); end
    rst = 1'b1;
    #1;
    checks++; if (bus.arvalid !== 1'b0 || bus.rready !== 1'b0 || bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin failures++; $display("FAIL midburst_reset_outputs: arvalid=%b rready=%b resp_valid=%b req_ready=%b required 0000", bus.arvalid, bus.rready, bus.resp_valid, bus.req_ready); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n0 = ar_count;
    do_req(32'h0000_3000, 1'b0, d, m, c);
    checks++; if (ar_count !== n0 + 1 || d !== {mem_word(32'h3004), mem_word(32'h3000)}) begin failures++; $display("FAIL post_reset_refill: got n=%0d data=%h required 1/%h", ar_count - n0, d, {mem_word(32'h3004), mem_word(32'h3000)}); end
    n0 = ar_count;
    do_req(32'h0000_1008, 1'b0, d, m, c);
    checks++; if (ar_count !== n0 + 1) begin failures++; $display("FAIL post_reset_invalid: got %0d bursts required 1", ar_count - n0); end
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_uncached = 1'b0; bus.resp_ready = 1'b0;
    bus.inv_valid = 1'b0; bus.inv_index = '0;
    test_reset();
    test_cold_miss_hit();
    test_line_end();
    test_replacement();
    test_uncached();
    test_invalidate();
    test_backpressure();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/i_cache_axi_nway.md
Name: i_cache_axi_nway

Overview:
- Parametrised set-associative instruction cache with an AXI-style read-burst master port.
- Sits between the fetch stage and the AXI read arbiter.
- Returns up to FETCH_NUM consecutive instruction words per request, all from one cache line.
- Adds four features to the 2-way fixed-geometry cache:
  - configurable ways, sets and line size
  - round-robin replacement
  - uncached single-beat path
  - index-invalidate port with a ready/valid handshake and response backpressure

Parameters:
WAY_NUM, 4, ways per set; power of 2, 1..8
INDEX_WIDTH, 7, set index bits; SETS = 2^INDEX_WIDTH
OFFSET_WIDTH, 5, byte offset bits; WORDS = 2^(OFFSET_WIDTH-2), min 3
FETCH_NUM, 2, max words per response; 1..4, <= WORDS
TAG_WIDTH, 32-INDEX_WIDTH-OFFSET_WIDTH, derived tag width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_valid  in  1  fetch request valid
req_ready  out  1  request accepted when req_valid&req_ready
req_addr  in  32  word-aligned fetch address
req_uncached  in  1  bypass cache for this request
resp_valid  out  1  response valid
resp_ready  in  1  response consumed
resp_data  out  32*FETCH_NUM  word k at bits [32k+31:32k]
resp_mask  out  FETCH_NUM  word k valid
inv_valid  in  1  invalidate request
inv_ready  out  1  invalidate accepted
inv_index  in  INDEX_WIDTH  set to invalidate (all ways)
araddr  out  32  AXI read address
arlen  out  8  burst length-1
arvalid  out  1  address valid
arready  in  1  address accepted
rdata  in  32  read data
rvalid  in  1  data valid
rlast  in  1  last beat
rready  out  1  data ready

Behaviour:
- Reset (async, any state, mid-burst included):
  - state=IDLE
  - all valid bits and round-robin pointers cleared
  - outputs arvalid, rready, resp_valid, req_ready, inv_ready = 0
  - resp_data and resp_mask = 0
  - tag/data arrays are not reset
  - an interrupted AXI burst is abandoned; the arbiter is reset together with this block.
- States: IDLE, LOOKUP, MISS_AR, MISS_R, UNC_AR, UNC_R, RESP.
- IDLE:
  - req_ready=1 and inv_ready=1.
  - inv_valid has priority over req_valid: invalidate clears valid[inv_index] in all ways in that cycle, state stays IDLE.
  - Accepted request latches addr/uncached.
  - Uncached -> UNC_AR.
  - Cached -> arrays read synchronously at index -> LOOKUP.
- LOOKUP:
  - hit = valid & tag match on any way; at most one way matches.
  - Hit: load resp regs from the matching way -> RESP. Hit latency is 2 cycles, accept to resp_valid.
  - Miss: victim = rr_ptr[index] -> MISS_AR.
- MISS_AR:
  - araddr = {tag,index,OFFSET_WIDTH'b0}, arlen = WORDS-1, arvalid held until arready -> MISS_R.
- MISS_R:
  - rready=1; beat counter cnt starts at 0.
  - Each rvalid writes word cnt of the victim way.
  - Beats whose cnt lies in [off, off+FETCH_NUM) and below WORDS are captured into resp_data.
  - On the rlast beat:
    - write tag and set valid
    - rr_ptr[index] <= rr_ptr+1, wrapping modulo WAY_NUM
    - -> RESP
  - rlast before beat WORDS-1 or a missing rlast is a protocol error; behaviour is undefined and not checked.
- UNC_AR: araddr = req addr, arlen = 0; handshake -> UNC_R.
- UNC_R: capture rdata in word 0, resp_mask = 1 -> RESP. Cache state is untouched.
- RESP:
  - resp_valid=1; hold data stable until resp_ready -> IDLE.
  - No new request or invalidate is accepted until then.
- resp_mask (cached):
  - bit k = 1 iff off+k < WORDS, where off = addr[OFFSET_WIDTH-1:2]; words beyond the line end are masked and zero.
  - Example: WORDS=8, off=7, FETCH_NUM=2 -> mask=01.
- Replacement: the round-robin pointer advances only on refill, never on hit. Invalid ways are not preferred.
- Invalidate is never accepted outside IDLE; inv_ready=0 elsewhere.
- An invalidate to the set of an in-flight request cannot occur, because requests are serialised.
- AXI:
  - arvalid is never dropped before arready.
  - rready=1 only in MISS_R/UNC_R.
  - One outstanding transaction.

Test Plan:
1. Cold miss: addr 0x0000_1008 (off=2) -> one burst, araddr=0x0000_1000, arlen=7; after 8 beats, resp_data = beats 2,3, mask=11. Re-request the same addr -> hit, resp_valid exactly 2 cycles after accept, no arvalid.
2. Line-end boundary: addr 0x0000_101C, line resident -> mask=01, word1=0.
3. Replacement (WAY_NUM=4): five distinct tags to one index, then the first tag again -> sixth access misses. The victim sequence is ways 0,1,2,3,0.
4. Uncached: req_uncached=1, addr 0x1FC0_0004 -> araddr=0x1FC0_0004, arlen=0, mask=01. A following cached request to the same line still misses.
5. Invalidate: hit line at index 0x01, inv_index=0x01 while IDLE -> next request to the line misses. inv_valid together with req_valid -> invalidate taken first, request accepted next cycle.
6. Backpressure and reset:
   - resp_ready held 0 for 5 cycles -> resp_data stable and req_ready=0.
   - rst asserted mid-burst (beat 3) -> arvalid, rready and resp_valid fall immediately; the line is invalid after reset.
